// File: rtl/sprite_palette_unit.sv
// Multi-palette colour lookup with a 2-stage read pipeline and a frame-stepped fade to/from black.
// The fade level captured alongside each lookup scales that lookup's colour channels.
module sprite_palette_unit #(
   parameter int unsigned IDX_W       = 4,
   parameter int unsigned NUM_PAL     = 4,
   parameter int unsigned COLOR_W     = 4,
   parameter int unsigned STEP_FRAMES = 2,
   parameter int unsigned TRANSP_EN   = 1
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       wr_en,
   input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
   input  logic [IDX_W-1:0]           wr_idx,
   input  logic [3*COLOR_W-1:0]       wr_rgb,
   input  logic                       rd_valid,
   input  logic [$clog2(NUM_PAL)-1:0] rd_pal,
   input  logic [IDX_W-1:0]           rd_idx,
   input  logic                       frame_tick,
   input  logic                       fade_out_req,
   input  logic                       fade_in_req,
   output logic                       out_valid,
   output logic [COLOR_W-1:0]         red,
   output logic [COLOR_W-1:0]         green,
   output logic [COLOR_W-1:0]         blue,
   output logic                       transparent,
   output logic                       fade_busy,
   output logic [COLOR_W:0]           fade_level
);

   localparam int unsigned PAL_W   = $clog2(NUM_PAL);
   localparam int unsigned ENTRIES = NUM_PAL << IDX_W;
   localparam int unsigned RGB_W   = 3 * COLOR_W;
   localparam int unsigned LVL_W   = COLOR_W + 1;
   localparam int unsigned FULL    = 1 << COLOR_W;
   localparam int unsigned TICK_W  = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

   typedef enum logic [1:0] {StIdle, StFadeOut, StDark, StFadeIn} fade_state_e;

   logic [RGB_W-1:0]       pal_q [ENTRIES];
   logic [PAL_W+IDX_W-1:0] wr_addr, rd_addr;

   logic                   s1_valid_q, s1_zero_q;
   logic [RGB_W-1:0]       s1_rgb_q;
   logic [LVL_W-1:0]       s1_lvl_q;

   logic                   out_valid_q, transp_q;
   logic [COLOR_W-1:0]     red_q, green_q, blue_q;

   fade_state_e            state_q, state_d;
   logic [LVL_W-1:0]       level_q, level_d;
   logic [TICK_W-1:0]      tick_q, tick_d;
   logic                   step_now;

   assign wr_addr = {wr_pal, wr_idx};
   assign rd_addr = {rd_pal, rd_idx};

   // Product is 2*COLOR_W+1 bits wide so a full-scale level passes the colour through unchanged.
   function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                input logic [LVL_W-1:0]   l);
      logic [2*COLOR_W:0] prod;
      prod = {{(COLOR_W + 1){1'b0}}, c} * {{COLOR_W{1'b0}}, l};
      return COLOR_W'(prod >> COLOR_W);
   endfunction

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < ENTRIES; i++) pal_q[i] <= '0;
      end else if (wr_en) begin
         pal_q[wr_addr] <= wr_rgb;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_valid_q  <= 1'b0;
         s1_zero_q   <= 1'b0;
         s1_rgb_q    <= '0;
         s1_lvl_q    <= '0;
         out_valid_q <= 1'b0;
         transp_q    <= 1'b0;
         red_q       <= '0;
         green_q     <= '0;
         blue_q      <= '0;
      end else begin
         s1_valid_q  <= rd_valid;
         out_valid_q <= s1_valid_q;
         if (rd_valid) begin
            s1_rgb_q  <= pal_q[rd_addr];
            s1_zero_q <= (rd_idx == '0) && (TRANSP_EN != 0);
            s1_lvl_q  <= level_q;
         end
         if (s1_valid_q) begin
            red_q    <= scale(s1_rgb_q[3*COLOR_W-1 -: COLOR_W], s1_lvl_q);
            green_q  <= scale(s1_rgb_q[2*COLOR_W-1 -: COLOR_W], s1_lvl_q);
            blue_q   <= scale(s1_rgb_q[COLOR_W-1 -: COLOR_W], s1_lvl_q);
            transp_q <= s1_zero_q;
         end
      end
   end

   assign step_now = frame_tick && (tick_q == TICK_W'(STEP_FRAMES - 1));

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      tick_d  = tick_q;
      unique case (state_q)
         StIdle: begin
            if (fade_out_req) begin
               state_d = StFadeOut;
               tick_d  = '0;
            end
         end
         StFadeOut: begin
            if (frame_tick) tick_d = step_now ? '0 : tick_q + TICK_W'(1);
            if (step_now && level_q != '0) begin
               level_d = level_q - LVL_W'(1);
               if (level_q == LVL_W'(1)) state_d = StDark;
            end
         end
         StDark: begin
            if (fade_in_req) begin
               state_d = StFadeIn;
               tick_d  = '0;
            end
         end
         StFadeIn: begin
            if (frame_tick) tick_d = step_now ? '0 : tick_q + TICK_W'(1);
            if (step_now && level_q != LVL_W'(FULL)) begin
               level_d = level_q + LVL_W'(1);
               if (level_q == LVL_W'(FULL - 1)) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= StIdle;
         level_q <= LVL_W'(FULL);
         tick_q  <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         tick_q  <= tick_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign red         = red_q;
   assign green       = green_q;
   assign blue        = blue_q;
   assign transparent = transp_q;
   assign fade_busy   = (state_q == StFadeOut) || (state_q == StFadeIn);
   assign fade_level  = level_q;

endmodule

// File: tb/tb_sprite_palette_unit.sv
// Randomized and directed bench for sprite_palette_unit against a cycle-level behavioural model.
module tb_sprite_palette_unit;

   localparam int IDX_W = 4;
   localparam int NUM_PAL = 4;
   localparam int COLOR_W = 4;
   localparam int STEP = 2;
   localparam int FULL = 16;

   logic        Clk = 1'b0;
   logic        Reset, wr_en, rd_valid, frame_tick, fade_out_req, fade_in_req;
   logic [1:0]  wr_pal, rd_pal;
   logic [3:0]  wr_idx, rd_idx;
   logic [11:0] wr_rgb;
   logic        out_valid, transparent, fade_busy;
   logic [3:0]  red, green, blue;
   logic [4:0]  fade_level;

   int n_chk = 0;
   int n_err = 0;

   // Behavioural model state
   logic [11:0] m_pal [NUM_PAL][16];
   int          m_lvl, m_mode, m_tick;   // mode: 0 idle, 1 fading out, 2 dark, 3 fading in
   bit          m_p1_v, m_p1_z, m_ov, m_tr;
   logic [11:0] m_p1_rgb;
   int          m_p1_l, m_r, m_g, m_b;

   sprite_palette_unit #(
      .IDX_W(IDX_W), .NUM_PAL(NUM_PAL), .COLOR_W(COLOR_W), .STEP_FRAMES(STEP), .TRANSP_EN(1)
   ) dut (
      .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx),
      .wr_rgb(wr_rgb), .rd_valid(rd_valid), .rd_pal(rd_pal), .rd_idx(rd_idx),
      .frame_tick(frame_tick), .fade_out_req(fade_out_req), .fade_in_req(fade_in_req),
      .out_valid(out_valid), .red(red), .green(green), .blue(blue),
      .transparent(transparent), .fade_busy(fade_busy), .fade_level(fade_level)
   );

   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_step();
      if (Reset) begin
         foreach (m_pal[p, i]) m_pal[p][i] = '0;
         m_lvl = FULL; m_mode = 0; m_tick = 0;
         m_p1_v = 0; m_ov = 0; m_tr = 0; m_r = 0; m_g = 0; m_b = 0;
      end else begin
         m_ov = m_p1_v;
         if (m_p1_v) begin
            m_r  = int'(m_p1_rgb[11:8]) * m_p1_l / FULL;
            m_g  = int'(m_p1_rgb[7:4]) * m_p1_l / FULL;
            m_b  = int'(m_p1_rgb[3:0]) * m_p1_l / FULL;
            m_tr = m_p1_z;
         end
         m_p1_v = rd_valid;
         if (rd_valid) begin
            m_p1_rgb = m_pal[rd_pal][rd_idx];
            m_p1_z   = (rd_idx == 0);
            m_p1_l   = m_lvl;
         end
         if (wr_en) m_pal[wr_pal][wr_idx] = wr_rgb;
         case (m_mode)
            0: if (fade_out_req) begin m_mode = 1; m_tick = 0; end
            2: if (fade_in_req) begin m_mode = 3; m_tick = 0; end
            1, 3: if (frame_tick) begin
               m_tick++;
               if (m_tick == STEP) begin
                  m_tick = 0;
                  m_lvl += (m_mode == 1) ? -1 : 1;
                  if (m_mode == 1 && m_lvl == 0) m_mode = 2;
                  if (m_mode == 3 && m_lvl == FULL) m_mode = 0;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic cycle();
      @(posedge Clk);
      model_step();
      #1;
      check_eq("out_valid", int'(out_valid), int'(m_ov));
      check_eq("fade_busy", int'(fade_busy), int'(m_mode == 1 || m_mode == 3));
      check_eq("fade_level", int'(fade_level), m_lvl);
      check_eq("red", int'(red), m_r);
      check_eq("green", int'(green), m_g);
      check_eq("blue", int'(blue), m_b);
      check_eq("transparent", int'(transparent), int'(m_tr));
   endtask

   task automatic idle_in();
      Reset = 0; wr_en = 0; rd_valid = 0; frame_tick = 0; fade_out_req = 0; fade_in_req = 0;
   endtask

   task automatic write(input int p, input int i, input int rgb);
      wr_en = 1; wr_pal = 2'(p); wr_idx = 4'(i); wr_rgb = 12'(rgb);
   endtask

   task automatic read(input int p, input int i);
      rd_valid = 1; rd_pal = 2'(p); rd_idx = 4'(i);
   endtask

   task automatic expect_rgb(input string tag, input int r, input int g, input int b);
      check_eq({tag, "_r"}, int'(red), r);
      check_eq({tag, "_g"}, int'(green), g);
      check_eq({tag, "_b"}, int'(blue), b);
   endtask

   // Runs n frame ticks, each followed by a quiet cycle, keeping the current read request live.
   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         frame_tick = 1; cycle();
         frame_tick = 0; cycle();
      end
   endtask

   initial begin
      idle_in();
      wr_pal = 0; wr_idx = 0; wr_rgb = 0; rd_pal = 0; rd_idx = 0;
      Reset = 1; cycle(); cycle();
      check_eq("rst_level", int'(fade_level), FULL);
      check_eq("rst_valid", int'(out_valid), 0);
      check_eq("rst_busy", int'(fade_busy), 0);
      idle_in();

      // Basic write then read-back
      write(1, 5, 'h6CF); cycle(); idle_in();
      read(1, 5); cycle(); idle_in(); cycle();
      check_eq("lookup_valid", int'(out_valid), 1);
      expect_rgb("lookup", 6, 12, 15);
      check_eq("lookup_transp", int'(transparent), 0);
      cycle();
      check_eq("valid_drop", int'(out_valid), 0);
      expect_rgb("hold", 6, 12, 15);

      // Transparency flag
      read(3, 0); cycle(); read(3, 1); cycle(); idle_in();
      check_eq("transp_idx0", int'(transparent), 1);
      cycle();
      check_eq("transp_idx1", int'(transparent), 0);

      // Read-during-write returns old data, next read sees new data
      write(2, 3, 'h123); cycle(); idle_in();
      write(2, 3, 'hFFF); read(2, 3); cycle(); idle_in();
      read(2, 3); cycle(); idle_in();
      expect_rgb("rdw_old", 1, 2, 3);
      cycle();
      expect_rgb("rdw_new", 15, 15, 15);

      // Fade-in request ignored in idle
      fade_in_req = 1; cycle(); idle_in(); ticks(2);
      check_eq("fin_ignored_busy", int'(fade_busy), 0);
      check_eq("fin_ignored_lvl", int'(fade_level), FULL);

      // Fade out to half then to black
      write(0, 7, 'hF80); cycle(); idle_in();
      fade_out_req = 1; cycle(); idle_in();
      read(0, 7);
      ticks(16);
      check_eq("half_lvl", int'(fade_level), 8);
      check_eq("half_busy", int'(fade_busy), 1);
      cycle(); cycle();
      expect_rgb("half", 7, 4, 0);
      ticks(16); cycle(); cycle();
      check_eq("dark_lvl", int'(fade_level), 0);
      check_eq("dark_busy", int'(fade_busy), 0);
      expect_rgb("dark", 0, 0, 0);
      ticks(3);
      check_eq("dark_no_wrap", int'(fade_level), 0);

      // Fade back in
      fade_in_req = 1; cycle(); fade_in_req = 0;
      ticks(16);
      check_eq("fin_busy", int'(fade_busy), 1);
      ticks(16); cycle(); cycle();
      check_eq("fin_lvl", int'(fade_level), FULL);
      check_eq("fin_busy_end", int'(fade_busy), 0);
      expect_rgb("fin", 15, 8, 0);
      idle_in();

      // Reset mid-fade with reads in flight
      fade_out_req = 1; cycle(); fade_out_req = 0;
      read(0, 7); ticks(3);
      Reset = 1; write(0, 7, 'hABC); fade_in_req = 1; cycle(); idle_in();
      check_eq("mid_rst_lvl", int'(fade_level), FULL);
      check_eq("mid_rst_busy", int'(fade_busy), 0);
      check_eq("mid_rst_valid", int'(out_valid), 0);
      cycle();
      check_eq("mid_rst_valid2", int'(out_valid), 0);
      read(0, 7); cycle(); idle_in(); cycle();
      check_eq("post_rst_valid", int'(out_valid), 1);
      expect_rgb("post_rst", 0, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         Reset        = ($urandom_range(0, 499) == 0);
         wr_en        = ($urandom_range(0, 2) == 0);
         wr_pal       = 2'($urandom);
         wr_idx       = 4'($urandom);
         wr_rgb       = 12'($urandom);
         rd_valid     = 1'($urandom);
         rd_pal       = 2'($urandom);
         rd_idx       = 4'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            rd_pal = wr_pal; rd_idx = wr_idx;
         end
         frame_tick   = 1'($urandom);
         fade_out_req = ($urandom_range(0, 29) == 0);
         fade_in_req  = ($urandom_range(0, 29) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
